// File: rtl/shift_sequencer.sv
// Multi-cycle logarithmic shifter: one shared 2:1 stage bank is stepped through
// L passes, one bit of the shift amount per cycle, with valid/ready on both sides.
module shift_sequencer #(
  parameter int N = 32,
  parameter int L = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  input  logic [L-1:0] in_amt,
  input  logic [1:0]   in_op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROL = 2'b11;

  localparam int unsigned LAST_STAGE = L - 1;
  localparam logic [L:0]  ONE_W      = {{L{1'b0}}, 1'b1};
  localparam logic [L:0]  N_W        = (L+1)'(N);

  state_t       r_state;
  logic [N-1:0] r_work;
  logic [L-1:0] r_amt;
  logic [1:0]   r_op;
  logic [L-1:0] r_stage;
  logic         r_in_ready;
  logic         r_out_valid;
  logic         r_busy;

  logic [L:0]   w_step;
  logic [L-1:0] w_amt_sh;
  logic         w_amt_bit;
  logic [N-1:0] w_next_work;

  // One mux stage: shift by s with the fill rule of the selected op.
  // SRA may use the current MSB because every earlier stage preserved it.
  function automatic logic [N-1:0] apply_stage(input logic [N-1:0] data,
                                               input logic [1:0]   op,
                                               input logic [L:0]   s);
    logic [L:0] back;
    back = N_W - s;
    case (op)
      OP_SLL:  return data << s;
      OP_SRL:  return data >> s;
      OP_SRA:  return $signed(data) >>> s;
      OP_ROL:  return (data << s) | (data >> back);
      default: return data;
    endcase
  endfunction

  // Stage bank: pass through unless the amount bit of the current stage is set.
  always_comb begin
    w_step      = ONE_W << r_stage;
    w_amt_sh    = r_amt >> r_stage;
    w_amt_bit   = w_amt_sh[0];
    w_next_work = r_work;
    if (w_amt_bit) begin
      w_next_work = apply_stage(r_work, r_op, w_step);
    end else begin
      w_next_work = r_work;
    end
  end

  // Sequencer FSM with registered handshake and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_work      <= {N{1'b0}};
      r_amt       <= {L{1'b0}};
      r_op        <= 2'b00;
      r_stage     <= {L{1'b0}};
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid && r_in_ready) begin
            r_work     <= in_data;
            r_amt      <= in_amt;
            r_op       <= in_op;
            r_stage    <= {L{1'b0}};
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          r_work <= w_next_work;
          if (r_stage == LAST_STAGE[L-1:0]) begin
            r_out_valid <= 1'b1;
            r_state     <= ST_DONE;
          end else begin
            r_stage <= r_stage + {{(L-1){1'b0}}, 1'b1};
          end
        end
        ST_DONE: begin
          // No bypass: a new request can only be taken from IDLE next cycle.
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign out_data  = r_work;

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: directed cases plus random requests
// compared against a plain-arithmetic shift model.
module tb_shift_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [4:0]  in_amt;
  logic [1:0]  in_op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  shift_sequencer #(.N(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference: a single whole-amount shift computed directly.
  function automatic logic [31:0] model(input logic [31:0] d, input int amt, input logic [1:0] op);
    logic [63:0] dbl;
    logic [31:0] fill;
    case (op)
      2'b00: return d << amt;
      2'b01: return d >> amt;
      2'b10: begin
        fill = d[31] ? ~(32'hFFFF_FFFF >> amt) : 32'h0;
        return (d >> amt) | fill;
      end
      default: begin
        dbl = {d, d} << amt;
        return dbl[63:32];
      end
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits up to 20 edges for out_valid; returns edges elapsed and whether
  // busy stayed high / in_ready stayed low throughout.
  task automatic wait_result(output int lat, output bit side_ok);
    lat = 0;
    side_ok = 1'b1;
    while (lat < 20) begin
      tick();
      lat++;
      side_ok &= (busy === 1'b1) && (in_ready === 1'b0);
      if (out_valid === 1'b1) break;
    end
  endtask

  task automatic run_req(input logic [31:0] d, input logic [4:0] a, input logic [1:0] op,
                         input int stall, input string tag);
    int w;
    int lat;
    bit side_ok;
    bit stall_ok;
    logic [31:0] held;
    w = 0;
    while (in_ready !== 1'b1 && w < 20) begin
      tick();
      w++;
    end
    check_val({tag, "_idle_rdy"}, 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    in_data   = d;
    in_amt    = a;
    in_op     = op;
    out_ready = (stall == 0);
    tick();
    in_valid = 1'b0;
    in_data  = $urandom;
    in_amt   = 5'($urandom);
    in_op    = 2'($urandom);
    wait_result(lat, side_ok);
    check_val({tag, "_lat"}, 32'(lat), 32'd5);
    check_val({tag, "_data"}, out_data, model(d, int'(a), op));
    check_val({tag, "_busy_noready"}, 32'(side_ok), 32'd1);
    held = out_data;
    stall_ok = 1'b1;
    for (int i = 0; i < stall; i++) begin
      tick();
      stall_ok &= (out_valid === 1'b1) && (out_data === held) && (in_ready === 1'b0);
    end
    check_val({tag, "_stall"}, 32'(stall_ok), 32'd1);
    out_ready = 1'b1;
    tick();
    check_val({tag, "_vld_drop"}, {30'd0, out_valid, busy}, 32'd0);
    check_val({tag, "_rdy_back"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    bit side_ok;
    bit ok;
    bit seen;
    logic [31:0] held;

    rst = 1'b1; in_valid = 1'b0; in_data = 32'h0; in_amt = 5'd0; in_op = 2'b00; out_ready = 1'b1;
    tick(); tick();
    check_val("reset_state", {28'd0, in_ready, out_valid, busy, 1'b0}, {28'd0, 1'b1, 1'b0, 1'b0, 1'b0});
    check_val("reset_data", out_data, 32'h0);

    // Reset wins over a simultaneous request.
    in_valid = 1'b1; in_data = 32'hFFFF_FFFF; in_amt = 5'd3;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    tick();
    check_val("rst_vs_valid", {30'd0, busy, in_ready}, 32'd1);

    run_req(32'h0000_0001, 5'd31, 2'b00, 0, "sll31");
    run_req(32'h8000_0000, 5'd4,  2'b10, 0, "sra4");
    run_req(32'h8000_0000, 5'd4,  2'b01, 1, "srl4");
    run_req(32'h8000_0001, 5'd1,  2'b11, 0, "rol1");
    run_req(32'h1234_5678, 5'd16, 2'b11, 2, "rol16");
    run_req(32'hDEAD_BEEF, 5'd0,  2'b10, 0, "sra0");
    run_req(32'hCAFE_F00D, 5'd0,  2'b11, 0, "rol0");
    check_val("tp_sra", model(32'h8000_0000, 4, 2'b10), 32'hF800_0000);

    // Backpressure with a competing request held during the stall.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h0F0F_0000; in_amt = 5'd8; in_op = 2'b01;
    tick();
    in_valid = 1'b0;
    wait_result(lat, side_ok);
    check_val("bp_lat", 32'(lat), 32'd5);
    check_val("bp_data", out_data, 32'h000F_0F00);
    held = out_data;
    in_valid = 1'b1; in_data = 32'h0000_00FF; in_amt = 5'd4; in_op = 2'b00;
    ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      ok &= (out_valid === 1'b1) && (out_data === held) && (in_ready === 1'b0) && (busy === 1'b1);
    end
    check_val("bp_stall", 32'(ok), 32'd1);
    out_ready = 1'b1;
    tick();
    check_val("bp_handshake", {30'd0, out_valid, in_ready}, 32'd1);
    tick();
    check_val("bp_accept_b", {30'd0, busy, in_ready}, 32'd2);
    in_valid = 1'b0;
    wait_result(lat, side_ok);
    check_val("bp_b_lat", 32'(lat), 32'd5);
    check_val("bp_b_data", out_data, 32'h0000_0FF0);
    tick();
    check_val("bp_b_drop", 32'(out_valid), 32'd0);

    // Reset while stage 2 is being applied: nothing may be emitted.
    in_valid = 1'b1; in_data = 32'h1111_1111; in_amt = 5'd7; in_op = 2'b00;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_val("midrst_state", {29'd0, in_ready, out_valid, busy}, {29'd0, 1'b1, 1'b0, 1'b0});
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      seen |= (out_valid === 1'b1) || (busy === 1'b1);
    end
    check_val("midrst_no_emit", 32'(seen), 32'd0);
    run_req(32'h0000_0003, 5'd2, 2'b00, 0, "post_rst");

    for (int n = 0; n < 40; n++) begin
      run_req($urandom, 5'($urandom), 2'($urandom), int'($urandom_range(0, 2)), $sformatf("rnd%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Multi-cycle logarithmic shifter controller.
- Accepts one shift request over a valid/ready handshake.
- Steps a single shared 2:1-mux stage bank through log2(N) passes, one bit of the shift amount per cycle.
- Returns the result over a valid/ready handshake.
- Sits between the ALU issue logic and the shifter datapath. It replaces a full-width combinational barrel shifter where area matters more than latency.

Parameters:
- N, 32, data width in bits; power of two, ≥ 2.
- L, $clog2(N), number of shift stages and width of the shift amount.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  request present
- in_ready  output  1  block can accept a request
- in_data  input  N  operand
- in_amt  input  L  shift amount, 0..N-1
- in_op  input  2  00 SLL, 01 SRL, 10 SRA, 11 ROL (rotate left)
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts result
- out_data  output  N  shifted result
- busy  output  1  high in SHIFT or DONE

Behaviour:
- One clock, clk. rst is synchronous and active-high, sampled on the rising edge of clk.
- Reset values:
  - state = IDLE
  - in_ready = 1
  - out_valid = 0
  - busy = 0
  - out_data = 0
  - internal data, amount, op and stage registers = 0
- States: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: capture in_data into the work register, in_amt and in_op into registers, set stage k = 0, go to SHIFT.
  - No capture without in_valid.
- SHIFT:
  - in_ready = 0.
  - Each cycle, apply stage k to the work register:
    - If amt[k] = 1, shift by 2^k per op.
    - If amt[k] = 0, pass through unchanged.
  - Increment k each cycle. When k = L-1 is applied, go to DONE.
  - Every stage is visited regardless of amount; there is no early exit. Latency is fixed.
- Op semantics per stage (shift by s = 2^k):
  - SLL: zero-fill at the LSBs.
  - SRL: zero-fill at the MSBs.
  - SRA: fill with the operand's original MSB. Because the MSB is preserved stage to stage, the current MSB may be used.
  - ROL: bits shifted out of the MSB re-enter at the LSB.
  - Composition of stages equals a single shift by in_amt.
- DONE:
  - out_valid = 1. out_data = work register, held stable while out_valid & !out_ready.
  - On out_ready: out_valid falls the next cycle and the block returns to IDLE.
- out_data is driven from the work register at all times. Its value is defined only while out_valid = 1.
- Timing:
  - out_valid rises exactly L rising edges after the accepting edge.
  - in_ready returns 1 the cycle after the output handshake. There is no same-cycle bypass from DONE to a new accept.
  - Minimum initiation interval is L+2 cycles.
- Amount 0: the operand passes through unchanged, still with L-cycle latency.
- in_valid while busy: ignored, because in_ready = 0. The requester must hold in_valid and its data until accepted.
- Reset mid-operation, in SHIFT or DONE: the operation is aborted and discarded, all outputs take reset values on the next cycle, and no out_valid pulse occurs.
- rst and in_valid in the same cycle: reset wins; the request is not accepted.
- Op 11 with amount 0 is legal and returns the operand.

Test Plan:
- SLL, in_data = 0x0000_0001, amt = 31, out_ready = 1 -> out_data = 0x8000_0000, out_valid high exactly 5 edges after accept, one cycle wide.
- SRA, in_data = 0x8000_0000, amt = 4 -> 0xF800_0000. Same operand with SRL -> 0x0800_0000.
- ROL, in_data = 0x8000_0001, amt = 1 -> 0x0000_0003. ROL of 0x1234_5678 by 16 -> 0x5678_1234.
- amt = 0 with SRA, in_data = 0xDEAD_BEEF -> 0xDEAD_BEEF after 5 cycles. busy is high throughout; in_ready is low throughout.
- Backpressure: hold out_ready = 0 for 3 cycles after out_valid -> out_data stable and in_ready = 0 during the stall. A new request presented during the stall is not accepted, and is accepted the cycle after out_ready rises.
- Assert rst during SHIFT stage 2 -> next cycle in_ready = 1, out_valid = 0, busy = 0, and no result is ever emitted. A fresh SLL 0x3 by 2 then returns 0xC.
